qtestpd_onchip_memory3: RTL and testbench

Parametrised single-port on-chip RAM with an Avalon-MM slave interface, the next generation of the qtestpd on-chip memory. It adds configurable data and address width, byte enables, a selectable read pipeline with `readdatavalid`, and a post-reset zero-fill sequencer. It sits on the system interconnect as a pipelined slave with `waitrequest`, and it keeps the `clken`, `freeze` and `reset_req` sideband controls.

---
 rtl/qtestpd_onchip_memory3_if.sv | 38 +++
 rtl/qtestpd_onchip_memory3.sv | 96 +++++++++
 tb/tb_qtestpd_onchip_memory3.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/qtestpd_onchip_memory3_if.sv
// qtestpd_onchip_memory3 Avalon-MM slave bus
// plus clken/freeze/reset_req sideband controls
interface qtestpd_onchip_memory3_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] address;
  logic                  chipselect;
  logic                  read;
  logic                  write;
  logic [BE_WIDTH-1:0]   byteenable;
  logic [DATA_WIDTH-1:0] writedata;
  logic                  clken;
  logic                  freeze;
  logic                  reset_req;
  logic                  waitrequest;
  logic [DATA_WIDTH-1:0] readdata;
  logic                  readdatavalid;
  logic                  init_done;

  modport master (
    output address, chipselect, read, write,
    output byteenable, writedata,
    output clken, freeze, reset_req,
    input  waitrequest, readdata,
    input  readdatavalid, init_done
  );

  modport slave (
    input  address, chipselect, read, write,
    input  byteenable, writedata,
    input  clken, freeze, reset_req,
    output waitrequest, readdata,
    output readdatavalid, init_done
  );
endinterface

// File: rtl/qtestpd_onchip_memory3.sv
// qtestpd_onchip_memory3: single-port RAM, Avalon-MM slave,
// byte enables, 1/2-cycle read pipe, post-reset zero fill
module qtestpd_onchip_memory3 #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 7,
  parameter int OUTREG         = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic clk,
  input logic reset_n,
  qtestpd_onchip_memory3_if.slave bus
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int DEPTH    = 2 ** ADDR_WIDTH;

  typedef enum logic {CLEAR, READY} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  en;
  logic                  busy;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  v1;
  logic [DATA_WIDTH-1:0] d1;

  assign en     = bus.clken & ~bus.reset_req;
  assign busy   = (state == CLEAR) | ~en;
  assign wr_acc = bus.chipselect & bus.write & ~busy;
  assign rd_acc = bus.chipselect & bus.read
                & ~bus.write & ~busy;

  assign bus.waitrequest = busy;
  assign bus.init_done   = (state == READY);

  // Fill sequencer: walk cnt over the array, then go READY
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      cnt   <= '0;
    end else if (en && state == CLEAR) begin
      cnt <= cnt + 1'b1;
      if (cnt == ADDR_WIDTH'(DEPTH - 1))
        state <= READY;
    end
  end

  // RAM write port: zero fill or byte-masked bus write
  always_ff @(posedge clk) begin
    if (reset_n && en) begin
      if (state == CLEAR) begin
        mem[cnt] <= '0;
      end else if (wr_acc && !bus.freeze) begin
        for (int b = 0; b < BE_WIDTH; b++)
          if (bus.byteenable[b])
            mem[bus.address][8*b +: 8] <= bus.writedata[8*b +: 8];
      end
    end
  end

  // First read stage: data only loads on a read so it holds otherwise
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v1 <= 1'b0;
      d1 <= '0;
    end else if (en) begin
      v1 <= rd_acc;
      if (rd_acc)
        d1 <= mem[bus.address];
    end
  end

  if (OUTREG != 0) begin : g_outreg
    logic                  v2;
    logic [DATA_WIDTH-1:0] d2;

    // Optional output register adding one cycle of latency
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        v2 <= 1'b0;
        d2 <= '0;
      end else if (en) begin
        v2 <= v1;
        if (v1)
          d2 <= d1;
      end
    end

    assign bus.readdata      = d2;
    assign bus.readdatavalid = v2;
  end else begin : g_direct
    assign bus.readdata      = d1;
    assign bus.readdatavalid = v1;
  end
endmodule

// File: tb/tb_qtestpd_onchip_memory3.sv
// tb_qtestpd_onchip_memory3: directed checks of a latency-1
// and a latency-2 instance driven with identical stimulus
module tb_qtestpd_onchip_memory3;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [6:0]  address;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        clken;
  logic        freeze;
  logic        reset_req;

  int checks   = 0;
  int failures = 0;
  int n;

  always #5 clk = ~clk;

  qtestpd_onchip_memory3_if #(.DATA_WIDTH(32), .ADDR_WIDTH(7)) m0 ();
  qtestpd_onchip_memory3_if #(.DATA_WIDTH(32), .ADDR_WIDTH(7)) m1 ();

  assign m0.address    = address;
  assign m0.chipselect = chipselect;
  assign m0.read       = read;
  assign m0.write      = write;
  assign m0.byteenable = byteenable;
  assign m0.writedata  = writedata;
  assign m0.clken      = clken;
  assign m0.freeze     = freeze;
  assign m0.reset_req  = reset_req;
  assign m1.address    = address;
  assign m1.chipselect = chipselect;
  assign m1.read       = read;
  assign m1.write      = write;
  assign m1.byteenable = byteenable;
  assign m1.writedata  = writedata;
  assign m1.clken      = clken;
  assign m1.freeze     = freeze;
  assign m1.reset_req  = reset_req;

  qtestpd_onchip_memory3 #(
    .DATA_WIDTH(32), .ADDR_WIDTH(7),
    .OUTREG(0), .CLEAR_ON_RESET(1)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(m0.slave)
  );

  qtestpd_onchip_memory3 #(
    .DATA_WIDTH(32), .ADDR_WIDTH(7),
    .OUTREG(1), .CLEAR_ON_RESET(1)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(m1.slave)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_fill(output int cnt);
    cnt = 0;
    while (m0.waitrequest && cnt < 300) begin
      tick();
      cnt++;
    end
  endtask

  task automatic do_write(input logic [6:0] a,
                          input logic [31:0] d,
                          input logic [3:0] be,
                          input logic frz);
    address    = a;
    writedata  = d;
    byteenable = be;
    freeze     = frz;
    chipselect = 1'b1;
    write      = 1'b1;
    #1;
    chk("wr_wait", m0.waitrequest, 0);
    tick();
    write      = 1'b0;
    chipselect = 1'b0;
    freeze     = 1'b0;
  endtask

  task automatic do_read(input string tag,
                         input logic [6:0] a,
                         input logic [31:0] exp);
    address    = a;
    chipselect = 1'b1;
    read       = 1'b1;
    tick();
    read       = 1'b0;
    chipselect = 1'b0;
    chk({tag, "_l1_v"}, m0.readdatavalid, 1);
    chk({tag, "_l1_d"}, m0.readdata, exp);
    chk({tag, "_l2_v_early"}, m1.readdatavalid, 0);
    tick();
    chk({tag, "_l1_v_off"}, m0.readdatavalid, 0);
    chk({tag, "_l2_v"}, m1.readdatavalid, 1);
    chk({tag, "_l2_d"}, m1.readdata, exp);
  endtask

  task automatic stall_read(input string tag, input bit use_rr);
    address    = 7'd20;
    chipselect = 1'b1;
    read       = 1'b1;
    tick();
    read       = 1'b0;
    chipselect = 1'b0;
    if (use_rr) reset_req = 1'b1;
    else        clken     = 1'b0;
    #1;
    chk({tag, "_wait"}, m1.waitrequest, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk({tag, "_l2_held_off"}, m1.readdatavalid, 0);
      chk({tag, "_l1_held_on"}, m0.readdatavalid, 1);
    end
    clken     = 1'b1;
    reset_req = 1'b0;
    tick();
    chk({tag, "_l2_v"}, m1.readdatavalid, 1);
    chk({tag, "_l2_d"}, m1.readdata, 32'hDEADBEEF);
    chk({tag, "_l1_v_off"}, m0.readdatavalid, 0);
    chk({tag, "_l1_d_hold"}, m0.readdata, 32'hDEADBEEF);
    tick();
    chk({tag, "_l2_v_off"}, m1.readdatavalid, 0);
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    byteenable = '0;
    writedata  = '0;
    clken      = 1'b1;
    freeze     = 1'b0;
    reset_req  = 1'b0;
    tick();
    tick();
    chk("rst_rdv0", m0.readdatavalid, 0);
    chk("rst_rdv1", m1.readdatavalid, 0);
    chk("rst_rd0", m0.readdata, 0);
    chk("rst_rd1", m1.readdata, 0);
    chk("rst_init", m0.init_done, 0);
    chk("rst_wait", m0.waitrequest, 1);

    reset_n = 1'b1;
    count_fill(n);
    chk("fill_len", n, 128);
    chk("fill_done0", m0.init_done, 1);
    chk("fill_done1", m1.init_done, 1);
    chk("fill_wait", m1.waitrequest, 0);
    do_read("clr0", 7'd0, 32'h0);
    do_read("clr64", 7'd64, 32'h0);
    do_read("clr127", 7'd127, 32'h0);

    do_write(7'd5, 32'hAABBCCDD, 4'hF, 1'b0);
    do_write(7'd5, 32'h11223344, 4'h5, 1'b0);
    do_read("be5", 7'd5, 32'hAA22CC44);

    for (int i = 0; i < 4; i++)
      do_write(7'(i), 32'(i + 1), 4'hF, 1'b0);
    for (int i = 0; i < 6; i++) begin
      chipselect = (i < 4);
      read       = (i < 4);
      address    = 7'(i);
      tick();
      chk("b2b_l1_v", m0.readdatavalid, (i < 4));
      if (i < 4) chk("b2b_l1_d", m0.readdata, i + 1);
      chk("b2b_l2_v", m1.readdatavalid, (i >= 1 && i <= 4));
      if (i >= 1 && i <= 4) chk("b2b_l2_d", m1.readdata, i);
    end
    chipselect = 1'b0;
    read       = 1'b0;

    do_write(7'd9, 32'h12345678, 4'hF, 1'b1);
    do_read("frz9", 7'd9, 32'h0);

    address    = 7'd30;
    writedata  = 32'h55;
    byteenable = 4'hF;
    chipselect = 1'b1;
    read       = 1'b1;
    write      = 1'b1;
    tick();
    chipselect = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    chk("rw_l1_v", m0.readdatavalid, 0);
    tick();
    chk("rw_l2_v", m1.readdatavalid, 0);
    do_read("rw30", 7'd30, 32'h55);

    do_write(7'd20, 32'hDEADBEEF, 4'hF, 1'b0);
    do_read("raw20", 7'd20, 32'hDEADBEEF);
    stall_read("stall_ck", 1'b0);
    stall_read("stall_rr", 1'b1);

    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (50) tick();
    chk("mid_wait", m0.waitrequest, 1);
    reset_n = 1'b0;
    tick();
    chk("mid_rst_init", m0.init_done, 0);
    reset_n = 1'b1;
    count_fill(n);
    chk("mid_fill_len", n, 128);
    chk("mid_done", m1.init_done, 1);

    do_write(7'd5, 32'hCAFEF00D, 4'hF, 1'b0);
    address    = 7'd5;
    chipselect = 1'b1;
    read       = 1'b1;
    tick();
    chipselect = 1'b0;
    read       = 1'b0;
    reset_n    = 1'b0;
    tick();
    chk("fly_l1_v", m0.readdatavalid, 0);
    chk("fly_l2_v", m1.readdatavalid, 0);
    chk("fly_l2_d", m1.readdata, 0);
    reset_n = 1'b1;
    tick();
    chk("fly_l2_v_late", m1.readdatavalid, 0);
    count_fill(n);
    chk("fly_fill_len", n, 127);
    do_read("refill5", 7'd5, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
